dut_vector_sequencer: RTL

Sequential stimulus controller for the combinational `dut` netlists in the test suite. It stores up to `DEPTH` input vectors, applies them one at a time to the DUT input bus, and waits a programmable settle time. It then captures the DUT output and streams each result out over a valid/ready port while folding it into a rotating-XOR signature. This replaces the single-vector `$readmemb` flow with a clocked, multi-vector, back-pressured one.

---
 rtl/dut_vector_sequencer_pkg.sv | 43 ++++
 rtl/dut_vector_sequencer_if.sv | 45 ++++
 rtl/dut_vector_sequencer_vec_store.sv | 39 +++
 rtl/dut_vector_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/dut_vector_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// dut_seq_pkg
// Shared definitions for the vector sequencer:
//   - seq_state_e : sequencer FSM states (IDLE, WAIT, EMIT)
//   - *_DEF       : default IN_W / OUT_W / DEPTH / SETTLE parameter values
//   - sig_step()  : one rotate-left-by-one then XOR step of the result
//                   signature, for any width up to SIG_MAX bits
// -----------------------------------------------------------------------------
package dut_seq_pkg;

    localparam int IN_W_DEF   = 30;
    localparam int OUT_W_DEF  = 10;
    localparam int DEPTH_DEF  = 16;
    localparam int SETTLE_DEF = 1;

    // Widest signature sig_step can fold; callers zero-extend into it.
    localparam int SIG_MAX = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EMIT = 2'd2
    } seq_state_e;

    // Rotate the low w bits of s left by one, then XOR in d.
    // Bits at and above w stay zero as long as d is zero there.
    function automatic logic [SIG_MAX-1:0] sig_step(
        input logic [SIG_MAX-1:0] s,
        input logic [SIG_MAX-1:0] d,
        input int                 w
    );
        logic [SIG_MAX-1:0] r;
        r    = '0;
        r[0] = s[w-1];
        for (int i = 1; i < SIG_MAX; i++) begin
            if (i < w) begin
                r[i] = s[i-1];
            end
        end
        return r ^ d;
    endfunction

endpackage : dut_seq_pkg

// File: rtl/dut_vector_sequencer_if.sv
// -----------------------------------------------------------------------------
// dut_seq_if
// Bundles the sequencer's bus signals.
//   Store write : wr_en, wr_addr, wr_data
//   Run control : start, num_vec, busy, done, sig
//   DUT drive   : dut_in (to the DUT), dut_out (from the DUT)
//   Result port : res_valid, res_ready, res_data, res_idx (valid/ready)
// Modports:
//   master - the sequencer itself (drives dut_in, results and status)
//   slave  - the environment (drives writes, start, dut_out, res_ready)
// -----------------------------------------------------------------------------
interface dut_seq_if #(
    parameter int IN_W  = dut_seq_pkg::IN_W_DEF,
    parameter int OUT_W = dut_seq_pkg::OUT_W_DEF,
    parameter int DEPTH = dut_seq_pkg::DEPTH_DEF
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int NV_W  = IDX_W + 1;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_addr;
    logic [IN_W-1:0]   wr_data;
    logic              start;
    logic [NV_W-1:0]   num_vec;
    logic [IN_W-1:0]   dut_in;
    logic [OUT_W-1:0]  dut_out;
    logic              res_valid;
    logic              res_ready;
    logic [OUT_W-1:0]  res_data;
    logic [IDX_W-1:0]  res_idx;
    logic              busy;
    logic              done;
    logic [OUT_W-1:0]  sig;

    modport master (
        input  wr_en, wr_addr, wr_data, start, num_vec, dut_out, res_ready,
        output dut_in, res_valid, res_data, res_idx, busy, done, sig
    );

    modport slave (
        output wr_en, wr_addr, wr_data, start, num_vec, dut_out, res_ready,
        input  dut_in, res_valid, res_data, res_idx, busy, done, sig
    );

endinterface : dut_seq_if

// File: rtl/dut_vector_sequencer_vec_store.sv
// -----------------------------------------------------------------------------
// vec_store
// DEPTH x IN_W vector store: one synchronous write port, one asynchronous
// read port. The contents are deliberately not reset so stored vectors
// survive a sequencer reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write index
//   wdata : write data
//   raddr : read index
//   rdata : read data (combinational, pre-edge contents)
// -----------------------------------------------------------------------------
module vec_store #(
    parameter int IN_W  = dut_seq_pkg::IN_W_DEF,
    parameter int DEPTH = dut_seq_pkg::DEPTH_DEF,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [IN_W-1:0]  wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [IN_W-1:0]  rdata
);

    logic [IN_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset branch on purpose; a reset loop over a
    // storage array turns RAM into thousands of flops and would also wipe
    // vectors that must survive a mid-run reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : vec_store

// File: rtl/dut_vector_sequencer.sv
// -----------------------------------------------------------------------------
// dut_vector_sequencer
// Applies up to DEPTH stored vectors to a combinational DUT one at a time,
// holds each for SETTLE cycles, captures the DUT output, streams it out on
// a valid/ready port and folds it into a rotate-XOR signature.
//   clk  : sole clock, rising edge
//   rst  : asynchronous, active-high reset (vector store is not reset)
//   bus  : dut_seq_if.master - store writes, run control, DUT drive,
//          result stream and status (busy, done, sig)
// -----------------------------------------------------------------------------
module dut_vector_sequencer
    import dut_seq_pkg::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic      clk,
    input  logic      rst,
    dut_seq_if.master bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int NV_W  = IDX_W + 1;
    localparam int CNT_W = $clog2(SETTLE + 1);

    seq_state_e       state_q,     state_d;
    logic [IDX_W-1:0] idx_q,       idx_d;
    logic [NV_W-1:0]  n_q,         n_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [IN_W-1:0]  dut_in_q,    dut_in_d;
    logic             res_valid_q, res_valid_d;
    logic [OUT_W-1:0] res_data_q,  res_data_d;
    logic [IDX_W-1:0] res_idx_q,   res_idx_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;
    logic [OUT_W-1:0] sig_q,       sig_d;

    logic             store_we;
    logic [IDX_W-1:0] rd_addr;
    logic [IN_W-1:0]  rd_data;
    logic             last_vec;

    // Writes are only honoured while idle so a run sees a frozen store.
    assign store_we = bus.wr_en && (state_q == IDLE);

    // Idle: a start loads entry 0. Otherwise the only load is the next entry
    // on an EMIT handshake.
    assign rd_addr  = (state_q == IDLE) ? '0 : idx_q + IDX_W'(1);

    assign last_vec = ({1'b0, idx_q} == (n_q - NV_W'(1)));

    vec_store #(
        .IN_W  (IN_W),
        .DEPTH (DEPTH)
    ) u_vec_store (
        .clk   (clk),
        .we    (store_we),
        .waddr (bus.wr_addr),
        .wdata (bus.wr_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // NOTE: every _d gets its hold value before the case statement, so no
    // path through the decode leaves a signal unassigned and no latch forms.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        dut_in_d    = dut_in_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_idx_d   = res_idx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        sig_d       = sig_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sig_d = '0;
                    if (bus.num_vec != '0) begin
                        n_d      = (bus.num_vec > NV_W'(DEPTH)) ? NV_W'(DEPTH)
                                                                : bus.num_vec;
                        idx_d    = '0;
                        dut_in_d = rd_data;
                        cnt_d    = CNT_W'(SETTLE);
                        busy_d   = 1'b1;
                        state_d  = WAIT;
                    end else begin
                        // Empty run: report completion without going busy.
                        done_d = 1'b1;
                    end
                end
            end

            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                // cnt==1 marks the edge after SETTLE full cycles of dut_in.
                if (cnt_q == CNT_W'(1)) begin
                    res_data_d  = bus.dut_out;
                    res_idx_d   = idx_q;
                    res_valid_d = 1'b1;
                    sig_d       = OUT_W'(sig_step(SIG_MAX'(sig_q),
                                                  SIG_MAX'(bus.dut_out),
                                                  OUT_W));
                    state_d     = EMIT;
                end
            end

            EMIT: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    if (last_vec) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        idx_d    = idx_q + IDX_W'(1);
                        dut_in_d = rd_data;
                        cnt_d    = CNT_W'(SETTLE);
                        state_d  = WAIT;
                    end
                end
            end

            default: begin
                state_d     = IDLE;
                busy_d      = 1'b0;
                res_valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            n_q         <= '0;
            cnt_q       <= '0;
            dut_in_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_idx_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sig_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            dut_in_q    <= dut_in_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_idx_q   <= res_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sig_q       <= sig_d;
        end
    end

    assign bus.dut_in    = dut_in_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_idx   = res_idx_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.sig       = sig_q;

endmodule : dut_vector_sequencer
